// File: rtl/conv_layer2_ctrl.sv
// conv_layer2_ctrl
//   Column sequencer for the 4-row x 12-PE layer-2 convolution array.
//   On start it clears the array and latches the filters. It then streams
//   num_cols ifmap columns from the column feature buffer into the array,
//   one column per cycle. Each valid summed output column is handed to a
//   downstream consumer through a one-deep valid/ready output register.
//   Backpressure on that register stalls both the array and the buffer.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle frame request, honoured only when idle
//   num_cols      ifmap column count, sampled on an accepted start
//   busy          high whenever the sequencer is not idle
//   done / err    one-cycle end-of-frame pulse; err flags a frame shorter than KW
//   arr_clr       one-cycle array clear (array rst_n = ~arr_clr)
//   wt_load       one-cycle filter-register load strobe
//   col_rd_en     feature-buffer read strobe, with col_addr
//   conv_en       array advance enable
//   psum_valid    output column valid, with out_col_idx
//   psum_ready    consumer accept
module conv_layer2_ctrl #(
  parameter int KW    = 3,
  parameter int COL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] num_cols,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             arr_clr,
  output logic             wt_load,
  output logic             col_rd_en,
  output logic [COL_W-1:0] col_addr,
  output logic             conv_en,
  output logic             psum_valid,
  input  logic             psum_ready,
  output logic [COL_W-1:0] out_col_idx
);

  localparam logic [COL_W-1:0] KW_C  = COL_W'(KW);
  localparam logic [COL_W-1:0] KW_M1 = COL_W'(KW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [COL_W-1:0] r_ncols;
  logic [COL_W-1:0] r_rd_cnt;
  logic [COL_W-1:0] r_en_cnt;
  logic [COL_W-1:0] r_out_idx;
  logic             r_data_vld;
  logic             r_psum_valid;
  logic             r_arr_clr;
  logic             r_wt_load;
  logic             r_done;
  logic             r_err;

  logic w_stall;
  logic w_conv_en;
  logic w_rd_more;
  logic w_col_rd_en;
  logic w_last_en;
  logic w_out_fire;

  // The array and the buffer hold whenever the output register is full and
  // not being drained; the buffer read rides on the same edge as the array
  // step, so the next column lands exactly when the array consumes the old one.
  assign w_stall     = r_psum_valid & ~psum_ready;
  assign w_conv_en   = (r_state == S_RUN) & r_data_vld & ~w_stall;
  assign w_rd_more   = (r_rd_cnt < r_ncols);
  assign w_col_rd_en = (r_state == S_PRIME) | (w_conv_en & w_rd_more);
  assign w_last_en   = w_conv_en & (r_en_cnt == (r_ncols - 1'b1));
  // The first KW-1 steps only fill the kernel window; no output yet.
  assign w_out_fire  = w_conv_en & (r_en_cnt >= KW_M1);

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign arr_clr     = r_arr_clr;
  assign wt_load     = r_wt_load;
  assign col_rd_en   = w_col_rd_en;
  assign col_addr    = (r_state == S_RUN) ? r_rd_cnt : '0;
  assign conv_en     = w_conv_en;
  assign psum_valid  = r_psum_valid;
  assign out_col_idx = r_out_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ncols    <= '0;
      r_rd_cnt   <= '0;
      r_en_cnt   <= '0;
      r_data_vld <= 1'b0;
      r_arr_clr  <= 1'b0;
      r_wt_load  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_arr_clr <= 1'b0;
      r_wt_load <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ncols    <= num_cols;
            r_rd_cnt   <= '0;
            r_en_cnt   <= '0;
            r_data_vld <= 1'b0;
            r_arr_clr  <= 1'b1;
            r_wt_load  <= 1'b1;
            r_state    <= S_INIT;
          end
        end
        S_INIT: begin
          // A frame narrower than the kernel produces nothing; finish at once.
          if (r_ncols < KW_C) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_PRIME;
          end
        end
        S_PRIME: begin
          r_rd_cnt   <= COL_W'(1);
          r_data_vld <= 1'b1;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (w_conv_en) begin
            r_en_cnt <= r_en_cnt + 1'b1;
            if (w_rd_more) begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end else begin
              r_data_vld <= 1'b0;
            end
          end
          if (w_last_en) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_psum_valid) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One-deep output register. A new column may overwrite only when the
  // current one is being accepted, since conv_en is already gated by stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psum_valid <= 1'b0;
      r_out_idx    <= '0;
    end else if (w_out_fire) begin
      r_psum_valid <= 1'b1;
      r_out_idx    <= r_en_cnt - KW_M1;
    end else if (r_psum_valid & psum_ready) begin
      r_psum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_layer2_ctrl.sv
module tb_conv_layer2_ctrl;
  localparam int KW    = 3;
  localparam int COL_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [COL_W-1:0] num_cols;
  logic             busy, done, err, arr_clr, wt_load, col_rd_en, conv_en, psum_valid;
  logic [COL_W-1:0] col_addr, out_col_idx;
  logic             psum_ready;

  conv_layer2_ctrl #(.KW(KW), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cols(num_cols),
    .busy(busy), .done(done), .err(err), .arr_clr(arr_clr), .wt_load(wt_load),
    .col_rd_en(col_rd_en), .col_addr(col_addr), .conv_en(conv_en),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .out_col_idx(out_col_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observation records, filled on the falling edge.
  int cyc = 0;
  int rd_q[$];
  int rd_cyc[$];
  int out_q[$];
  int out_cyc[$];
  int conv_cnt, pv_cnt, done_cnt, err_cnt, done_err_cnt, clr_cnt, wl_cnt;
  int clr_cyc, done_cyc, stall_viol, hold_viol, busy_viol, stall1_cyc;
  bit prev_pv, prev_rdy, prev_busy, prev_done;
  logic [COL_W-1:0] prev_idx;

  // Consumer behaviour: 0 always ready, 1 random, 2 hold off 4 cycles on idx 1.
  int rdy_mode = 0;
  int stall_left = 0;
  bit stall_used = 0;

  function automatic bit seq_ok(input int q[$], input int cnt);
    if (q.size() != cnt) return 1'b0;
    foreach (q[i]) if (q[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_pv = 0; prev_rdy = 0; prev_busy = 0; prev_done = 0; prev_idx = '0;
      end else begin
        if (col_rd_en) begin rd_q.push_back(int'(col_addr)); rd_cyc.push_back(cyc); end
        if (psum_valid && psum_ready) begin out_q.push_back(int'(out_col_idx)); out_cyc.push_back(cyc); end
        if (conv_en) conv_cnt++;
        if (psum_valid) pv_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) err_cnt++;
        if (done && err) done_err_cnt++;
        if (arr_clr) begin clr_cnt++; clr_cyc = cyc; end
        if (wt_load) wl_cnt++;
        if (psum_valid && !psum_ready && (conv_en || col_rd_en)) stall_viol++;
        if (psum_valid && !psum_ready && out_col_idx == 1) stall1_cyc++;
        if (prev_pv && !prev_rdy && !(psum_valid && out_col_idx == prev_idx)) hold_viol++;
        if (prev_busy && !busy && !prev_done) busy_viol++;
        prev_pv = psum_valid; prev_rdy = psum_ready; prev_idx = out_col_idx;
        prev_busy = busy; prev_done = done;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: psum_ready = 1'b1;
        1: psum_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left > 0) begin
            psum_ready = 1'b0;
            stall_left--;
          end else if (!stall_used && psum_valid && out_col_idx == 1) begin
            stall_used = 1;
            psum_ready = 1'b0;
            stall_left = 3;
          end else begin
            psum_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic clear_stats();
    rd_q.delete(); rd_cyc.delete(); out_q.delete(); out_cyc.delete();
    conv_cnt = 0; pv_cnt = 0; done_cnt = 0; err_cnt = 0; done_err_cnt = 0;
    clr_cnt = 0; wl_cnt = 0; clr_cyc = 0; done_cyc = 0;
    stall_viol = 0; hold_viol = 0; busy_viol = 0; stall1_cyc = 0;
  endtask

  task automatic run_frame(input int n, input int restart_at, input int bound, output bit timed_out);
    clear_stats();
    @(posedge clk); #1;
    num_cols = COL_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < bound; k++) begin
      start = (k == restart_at);
      @(posedge clk); #1;
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_cols = '0; psum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, arr_clr, wt_load, col_rd_en, col_addr, conv_en, psum_valid, out_col_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b clr=%b wl=%b rd=%b addr=%0d en=%b pv=%b idx=%0d, required all 0",
               busy, done, err, arr_clr, wt_load, col_rd_en, col_addr, conv_en, psum_valid, out_col_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit to;
    rdy_mode = 0;
    run_frame(8, -1, 200, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen, required within 200 cycles"); end
    checks++; if (clr_cnt != 1) begin errors++; $display("FAIL basic_arr_clr: got %0d pulses, required 1", clr_cnt); end
    checks++; if (wl_cnt != 1) begin errors++; $display("FAIL basic_wt_load: got %0d pulses, required 1", wl_cnt); end
    checks++; if (!seq_ok(rd_q, 8)) begin errors++; $display("FAIL basic_reads: got %0d reads, required addresses 0..7", rd_q.size()); end
    checks++;
    if (rd_cyc.size() != 8 || rd_cyc[rd_cyc.size()-1] - rd_cyc[0] != 7) begin
      errors++; $display("FAIL basic_read_consecutive: got %0d reads not on 8 consecutive cycles, required consecutive", rd_cyc.size());
    end
    checks++; if (conv_cnt != 8) begin errors++; $display("FAIL basic_conv_en: got %0d, required 8", conv_cnt); end
    checks++; if (!seq_ok(out_q, 6)) begin errors++; $display("FAIL basic_outputs: got %0d outputs, required indices 0..5", out_q.size()); end
    checks++;
    if (out_cyc.size() != 6 || out_cyc[out_cyc.size()-1] - out_cyc[0] != 5) begin
      errors++; $display("FAIL basic_back_to_back: got %0d outputs not back to back, required 6 consecutive", out_cyc.size());
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d, required 1", done_cnt); end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL basic_err: got %0d, required 0", err_cnt); end
  endtask

  task automatic test_stall();
    bit to;
    rdy_mode = 2; stall_used = 0; stall_left = 0;
    run_frame(5, -1, 200, to);
    rdy_mode = 0;
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: done not seen, required within 200 cycles"); end
    checks++; if (stall1_cyc != 4) begin errors++; $display("FAIL stall_hold_idx1: got %0d stalled cycles on idx 1, required 4", stall1_cyc); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_gating: got %0d cycles with conv_en/col_rd_en during stall, required 0", stall_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable unaccepted outputs, required 0", hold_viol); end
    checks++; if (!seq_ok(out_q, 3)) begin errors++; $display("FAIL stall_outputs: got %0d accepts, required indices 0..2 once each", out_q.size()); end
    checks++; if (!seq_ok(rd_q, 5)) begin errors++; $display("FAIL stall_reads: got %0d reads, required addresses 0..4", rd_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_short();
    bit to;
    int lens[2];
    lens[0] = 2; lens[1] = 0;
    rdy_mode = 0;
    foreach (lens[i]) begin
      run_frame(lens[i], -1, 50, to);
      checks++; if (to) begin errors++; $display("FAIL short%0d_timeout: done not seen, required within 50 cycles", lens[i]); end
      checks++;
      if (rd_q.size() != 0 || conv_cnt != 0 || pv_cnt != 0) begin
        errors++; $display("FAIL short%0d_activity: got reads=%0d conv=%0d pv=%0d, required 0/0/0", lens[i], rd_q.size(), conv_cnt, pv_cnt);
      end
      checks++;
      if (done_cnt != 1 || done_err_cnt != 1) begin
        errors++; $display("FAIL short%0d_done_err: got done=%0d done&err=%0d, required 1/1", lens[i], done_cnt, done_err_cnt);
      end
      checks++;
      if (done_cyc - clr_cyc != 1) begin
        errors++; $display("FAIL short%0d_done_timing: got done %0d cycles after INIT, required 1", lens[i], done_cyc - clr_cyc);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    rdy_mode = 0;
    run_frame(8, 3, 200, to);
    checks++; if (to) begin errors++; $display("FAIL restart_timeout: done not seen, required within 200 cycles"); end
    checks++; if (!seq_ok(out_q, 6)) begin errors++; $display("FAIL restart_outputs: got %0d outputs, required indices 0..5", out_q.size()); end
    checks++;
    if (done_cnt != 1 || clr_cnt != 1) begin
      errors++; $display("FAIL restart_single_frame: got done=%0d arr_clr=%0d, required 1/1", done_cnt, clr_cnt);
    end
    checks++; if (!seq_ok(rd_q, 8)) begin errors++; $display("FAIL restart_reads: got %0d reads, required addresses 0..7", rd_q.size()); end
  endtask

  task automatic test_mid_reset();
    bit to;
    bit seen;
    rdy_mode = 0;
    clear_stats();
    @(posedge clk); #1;
    num_cols = COL_W'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (rd_q.size() >= 3) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_wait: got %0d reads, required 3 within 50 cycles", rd_q.size()); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, arr_clr, wt_load, col_rd_en, col_addr, conv_en, psum_valid, out_col_idx} !== '0) begin
      errors++;
      $display("FAIL midrst_async_outputs: got busy=%b rd=%b addr=%0d en=%b pv=%b idx=%0d, required all 0",
               busy, col_rd_en, col_addr, conv_en, psum_valid, out_col_idx);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(3, -1, 100, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout: done not seen, required within 100 cycles"); end
    checks++; if (!seq_ok(rd_q, 3)) begin errors++; $display("FAIL midrst_reads: got %0d reads, required addresses 0..2", rd_q.size()); end
    checks++; if (!seq_ok(out_q, 1)) begin errors++; $display("FAIL midrst_outputs: got %0d outputs, required one with idx 0", out_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_random_long();
    bit to;
    rdy_mode = 1;
    run_frame(255, -1, 20000, to);
    rdy_mode = 0;
    checks++; if (to) begin errors++; $display("FAIL long_timeout: done not seen, required within 20000 cycles"); end
    checks++; if (!seq_ok(out_q, 253)) begin errors++; $display("FAIL long_outputs: got %0d outputs, required indices 0..252", out_q.size()); end
    checks++; if (!seq_ok(rd_q, 255)) begin errors++; $display("FAIL long_reads: got %0d reads, required addresses 0..254", rd_q.size()); end
    checks++; if (hold_viol != 0 || stall_viol != 0) begin errors++; $display("FAIL long_backpressure: got hold=%0d stall=%0d violations, required 0/0", hold_viol, stall_viol); end
    checks++; if (busy_viol != 0) begin errors++; $display("FAIL long_busy_after_done: got %0d early busy drops, required 0", busy_viol); end
    checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL long_done: got done=%0d err=%0d, required 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_random_frames();
    bit to;
    int n, exp_outs, exp_conv, exp_err;
    rdy_mode = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 20);
      exp_outs = (n >= KW) ? n - KW + 1 : 0;
      exp_conv = (n >= KW) ? n : 0;
      exp_err  = (n < KW) ? 1 : 0;
      run_frame(n, -1, 1000, to);
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: n=%0d done not seen, required within 1000 cycles", f, n); end
      checks++;
      if (!seq_ok(rd_q, exp_conv)) begin
        errors++; $display("FAIL rnd%0d_reads: n=%0d got %0d reads, required %0d in order", f, n, rd_q.size(), exp_conv);
      end
      checks++;
      if (!seq_ok(out_q, exp_outs) || conv_cnt != exp_conv) begin
        errors++; $display("FAIL rnd%0d_outputs: n=%0d got outs=%0d conv=%0d, required %0d/%0d", f, n, out_q.size(), conv_cnt, exp_outs, exp_conv);
      end
      checks++;
      if (done_cnt != 1 || err_cnt != exp_err || hold_viol != 0 || busy_viol != 0) begin
        errors++; $display("FAIL rnd%0d_status: n=%0d got done=%0d err=%0d hold=%0d busy=%0d, required 1/%0d/0/0",
                           f, n, done_cnt, err_cnt, hold_viol, busy_viol, exp_err);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_short();
    test_start_ignored();
    test_mid_reset();
    test_random_long();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
